// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised pipeline-stage register built from DEPTH chained skid slices.
// Optional stall counter (stall_cnt, perf_clr) is enabled by defining PIPE_STAGE_PERF_EN.

module pipe_stage_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);
    logic             m_v, s_v;
    logic [WIDTH-1:0] m_d, s_d;
    logic             accept, head_free;

    assign up_ready  = ~s_v;
    assign accept    = up_valid & ~s_v;
    assign head_free = ~m_v | dn_ready;
    assign dn_valid  = m_v;
    assign dn_data   = m_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= '0;
            s_d <= '0;
        end else if (flush) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (head_free) begin
            // an accept implies the skid is empty, so the new item goes straight to main
            if (accept) begin
                m_v <= 1'b1;
                m_d <= up_data;
                s_v <= 1'b0;
            end else if (s_v) begin
                m_v <= 1'b1;
                m_d <= s_d;
                s_v <= 1'b0;
            end else begin
                m_v <= 1'b0;
            end
        end else if (accept) begin
            s_v <= 1'b1;
            s_d <= up_data;
        end
    end
endmodule

module pipe_stage_buf #(
    parameter int           WIDTH     = 32,
    parameter int           DEPTH     = 1,
    parameter logic [255:0] NOP_VALUE = 256'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_PERF_EN
    ,
    input  logic                           perf_clr,
    output logic [31:0]                    stall_cnt
`endif
);
    localparam int CW = $clog2(2*DEPTH+1);
    localparam logic [WIDTH-1:0] NOP = NOP_VALUE[WIDTH-1:0];

    logic [DEPTH:0]            v, r;
    logic [DEPTH:0][WIDTH-1:0] d;
    logic                      in_hs, out_hs;

    assign v[0]     = in_valid;
    assign d[0]     = in_data;
    assign r[DEPTH] = out_ready;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slice
            pipe_stage_slice #(.WIDTH(WIDTH)) u_slice (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .up_valid (v[i]),
                .up_ready (r[i]),
                .up_data  (d[i]),
                .dn_valid (v[i+1]),
                .dn_ready (r[i+1]),
                .dn_data  (d[i+1])
            );
        end
    endgenerate

    assign in_ready  = r[0];
    assign out_valid = v[DEPTH];
    // bubbles present a harmless instruction downstream
    assign out_data  = v[DEPTH] ? d[DEPTH] : NOP;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (flush)
            count <= '0;
        else
            count <= count + CW'(in_hs) - CW'(out_hs);
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (perf_clr)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed steps on a DEPTH=2 instance, then random traffic on DEPTH=1..4
// checked against a plain FIFO occupancy model.
module tb_pipe_stage_buf;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [N-1:0]       in_ready_a, out_valid_a;
    logic [N-1:0][31:0] out_data_a;
    logic [N-1:0][3:0]  count_a;
`ifdef PIPE_STAGE_PERF_EN
    logic               perf_clr;
    logic [N-1:0][31:0] stall_a;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq [N][16];
    int          qh [N];
    int          qs [N];
    logic        pstall [N];
    logic [31:0] pdata [N];
    logic        hi [N];
    logic        ho [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int D  = g + 1;
            localparam int CW = $clog2(2*D+1);
            logic [CW-1:0] c;
            pipe_stage_buf #(.WIDTH(32), .DEPTH(D), .NOP_VALUE(32'h0000_0013)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (in_ready_a[g]),
                .in_data   (in_data),
                .out_valid (out_valid_a[g]),
                .out_ready (out_ready),
                .out_data  (out_data_a[g]),
                .count     (c)
`ifdef PIPE_STAGE_PERF_EN
                ,
                .perf_clr  (perf_clr),
                .stall_cnt (stall_a[g])
`endif
            );
            assign count_a[g] = 4'(c);
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // offer n consecutive items on instance 1, advancing only on handshake
    task automatic push_n(input int n, input logic [31:0] base);
        int   idx;
        logic h;
        idx = 0;
        for (int k = 0; k < 4*n+4 && idx < n; k++) begin
            in_valid = 1'b1; in_data = base + 32'(idx);
            h = in_ready_a[1];
            @(negedge clk);
            if (h) idx++;
        end
        in_valid = 1'b0;
        check("push_done", 32'(idx), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, n_out, w;
        logic h, seen_dead;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef PIPE_STAGE_PERF_EN
        perf_clr = 1'b0;
`endif
        #1;
        check("rst_out_valid", out_valid_a[1], 1'b0);
        check("rst_out_data",  out_data_a[1], 32'h13);
        check("rst_in_ready",  in_ready_a[1], 1'b1);
        check("rst_count",     count_a[1], 0);

        // streaming 1..4 with out_ready=1: two register stages of latency
        do_reset();
        out_ready = 1'b1;
        begin
            int exp_cnt [8] = '{0, 1, 2, 2, 2, 1, 0, 0};
            for (int k = 0; k < 8; k++) begin
                check("str_valid", out_valid_a[1], (k >= 2 && k <= 5));
                check("str_data",  out_data_a[1], (k >= 2 && k <= 5) ? 32'(k-1) : 32'h13);
                check("str_count", count_a[1], 32'(exp_cnt[k]));
                check("str_in_ready", in_ready_a[1], 1'b1);
                in_valid = (k < 4); in_data = 32'(k+1);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end

        // back-pressure: offer A0..A5 with out_ready=0
        do_reset();
        out_ready = 1'b0; idx = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = (idx < 6); in_data = 32'hA0 + 32'(idx);
            h = in_valid & in_ready_a[1];
            @(negedge clk);
            if (h) idx++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(idx), 4);
        check("bp_in_ready", in_ready_a[1], 1'b0);
        check("bp_count",    count_a[1], 4);
        check("bp_head_held", out_data_a[1], 32'hA0);
        out_ready = 1'b1; n_out = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_a[1]) begin
                check("bp_drain", out_data_a[1], 32'hA0 + 32'(n_out));
                n_out++;
            end
            @(negedge clk);
        end
        check("bp_ndrained", 32'(n_out), 4);
        check("bp_empty_valid", out_valid_a[1], 1'b0);
        check("bp_empty_nop", out_data_a[1], 32'h13);
        check("bp_empty_count", count_a[1], 0);

        // flush with a same-cycle in handshake
        do_reset();
        out_ready = 1'b0;
        push_n(3, 32'hB0);
        check("fl_count_pre", count_a[1], 3);
        check("fl_in_ready_pre", in_ready_a[1], 1'b1);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count",     count_a[1], 0);
        check("fl_out_valid", out_valid_a[1], 1'b0);
        check("fl_in_ready",  in_ready_a[1], 1'b1);
        check("fl_out_nop",   out_data_a[1], 32'h13);
        out_ready = 1'b1; seen_dead = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid_a[1] && out_data_a[1] == 32'hDEAD) seen_dead = 1'b1;
            @(negedge clk);
        end
        check("fl_no_dead", seen_dead, 1'b0);

        // asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b0;
        push_n(3, 32'hC0);
        check("ar_count_pre", count_a[1], 3);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid_a[1], 1'b0);
        check("ar_count",     count_a[1], 0);
        check("ar_in_ready",  in_ready_a[1], 1'b1);
        check("ar_out_nop",   out_data_a[1], 32'h13);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        @(negedge clk);
        in_valid = 1'b0;
        for (w = 0; w < 8 && !out_valid_a[1]; w++) @(negedge clk);
        check("ar_arrive", out_valid_a[1], 1'b1);
        check("ar_arrive_lat", 32'(w), 1);
        check("ar_data", out_data_a[1], 32'h55);

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        @(negedge clk);
        in_valid = 1'b0;
        for (w = 0; w < 8 && !out_valid_a[1]; w++) @(negedge clk);
        check("pf_valid", out_valid_a[1], 1'b1);
        check("pf_start", stall_a[1], 0);
        repeat (7) @(negedge clk);
        check("pf_seven", stall_a[1], 7);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        check("pf_clr", stall_a[1], 0);
`endif

        // random traffic on all depths against a FIFO model
        do_reset();
        for (int g = 0; g < N; g++) begin
            qh[g] = 0; qs[g] = 0; pstall[g] = 1'b0; pdata[g] = '0;
        end
        for (int cyc = 0; cyc < 10030; cyc++) begin
            for (int g = 0; g < N; g++) begin
                check("rnd_count", count_a[g], 32'(qs[g]));
                check("rnd_valid_nonempty", (out_valid_a[g] && qs[g] == 0), 1'b0);
                if (out_valid_a[g])
                    check("rnd_data", out_data_a[g], mq[g][qh[g]]);
                else
                    check("rnd_nop", out_data_a[g], 32'h13);
                if (qs[g] == 2*(g+1))
                    check("rnd_full_ready", in_ready_a[g], 1'b0);
                if (pstall[g]) begin
                    check("rnd_hold_valid", out_valid_a[g], 1'b1);
                    check("rnd_hold_data", out_data_a[g], pdata[g]);
                end
            end
            if (cyc < 10000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 99) == 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
            end
            for (int g = 0; g < N; g++) begin
                hi[g] = in_valid & in_ready_a[g];
                ho[g] = out_valid_a[g] & out_ready;
                pstall[g] = out_valid_a[g] & ~out_ready & ~flush;
                pdata[g] = out_data_a[g];
            end
            @(posedge clk);
            for (int g = 0; g < N; g++) begin
                if (flush) begin
                    qs[g] = 0;
                end else begin
                    if (ho[g]) begin qh[g] = (qh[g] + 1) % 16; qs[g]--; end
                    if (hi[g]) begin mq[g][(qh[g] + qs[g]) % 16] = in_data; qs[g]++; end
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < N; g++) begin
            check("drain_count", count_a[g], 0);
            check("drain_valid", out_valid_a[g], 1'b0);
            check("drain_ready", in_ready_a[g], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
